mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
MEM pipeline stage that consumes the EXE/MEM pipeline register outputs and performs loads and stores over a req/ack data-memory port.
- Generates byte enables and lane-replicated store data.
- Aligns and sign/zero-extends load data.
- Raises a stall request to the hazard detection unit while an access is outstanding.
- Non-memory instructions pass through combinationally to the MEM/WB register.

Parameters:
XLEN, 32, GPR/data width (only 32 supported)
RADDR_W, 5, register address width
F3_W, 3, funct3 width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
alu_val_i  in  XLEN  ALU result / effective address
rd_addr_i  in  RADDR_W  destination register
rd_we_i  in  1  register write enable
rs2_val_i  in  XLEN  store data
mem_re_i  in  1  load
mem_we_i  in  1  store
mem_mode_i  in  F3_W  funct3 (size/sign)
dmem_req_o  out  1  access request, held until ack
dmem_we_o  out  1  1=store
dmem_addr_o  out  XLEN  word-aligned address ({alu_val_i[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  XLEN  lane-replicated store data
dmem_rdata_i  in  XLEN  read word, valid with ack
dmem_ack_i  in  1  access complete
stall_o  out  1  to hazard unit: freeze IF..EXE/MEM
rd_val_o  out  XLEN  writeback value to MEM/WB
rd_addr_o  out  RADDR_W  = rd_addr_i
rd_we_o  out  1  write enable to MEM/WB
exc_misalign_o  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Clock clk_i, reset rst_i: single clock, reset synchronous and active-high.
- access = mem_re_i | mem_we_i. Store has priority if both are set: the access is treated as a store and no load data is written back.
- FSM states: IDLE, WAIT, DONE. Reset → IDLE, load register ldata_q=0.
- While rst_i=1: dmem_req_o=0, stall_o=0, rd_we_o=0, exc_misalign_o=0.
- IDLE, access=0:
  - No request; stall_o=0.
  - rd_val_o=alu_val_i, rd_we_o=rd_we_i.
  - Zero latency.
- IDLE, access=1:
  - dmem_req_o=1 (combinational) and stall_o=1.
  - ack same cycle → capture load into ldata_q, go to DONE.
  - Otherwise go to WAIT.
- WAIT:
  - req and all dmem_* outputs held stable; stall_o=1.
  - On ack: capture, go to DONE.
  - No timeout.
- DONE:
  - stall_o=0, no request.
  - rd_val_o = ldata_q for loads, alu_val_i for stores; rd_we_o = rd_we_i & ~mem_we_i.
  - Next state is IDLE unconditionally; upstream advances on this edge.
- Minimum memory-op latency: 2 cycles (one stall cycle). Each extra ack-wait cycle adds one.
- rd_we_o is forced to 0 whenever stall_o=1.
- Upstream inputs must be stable while stall_o=1. The hazard unit guarantees stall priority over flush.
- dmem_ack_i outside IDLE-with-request or WAIT is ignored.
- Store lanes, a = alu_val_i[1:0]:
  - SB (000): be=4'b0001<<a, wdata={4{rs2[7:0]}}.
  - SH (001): be=4'b0011<<{a[1],0}, wdata={2{rs2[15:0]}}.
  - SW (010) and any other funct3: be=4'b1111, wdata=rs2.
- Loads: dmem_be_o=4'b1111. The selected byte/half comes from lane a (half from a[1]).
  - LB (000) sign-extends, LBU (100) zero-extends.
  - LH (001) sign-extends, LHU (101) zero-extends.
  - LW (010) and any other funct3 take the full word.
- Reset mid-WAIT: the FSM returns to IDLE on that edge and the request drops. Any later ack is ignored.

Optional Feature:
Macro MEM_MISALIGN_EXC_EN. Misaligned means: half with a[0]=1, or word with a≠0.
- Defined: a misaligned access in IDLE issues no request and causes no stall.
  - exc_misalign_o=1 for that cycle.
  - rd_we_o=0.
  - The instruction retires as a bubble.
- Undefined: exc_misalign_o tied to 0.
  - Misaligned accesses proceed with truncated lane selection: half uses a[1], word ignores a.

Test Plan:
- alu_val_i=0x1234, rd_we_i=1, no access → same cycle rd_val_o=0x1234, rd_we_o=1, stall_o=0, dmem_req_o=0.
- LW addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF:
  - dmem_addr_o=0x100 and stall_o=1 for 3 cycles.
  - DONE: rd_val_o=0xDEADBEEF, rd_we_o=1.
- LB addr 0x103, rdata 0x80FFFFFF → rd_val_o=0xFFFFFF80. LBU same → 0x00000080.
- SH addr 0x202, rs2=0xAAAA5555, ack immediate:
  - be=4'b1100, wdata=0x55555555, addr=0x200, dmem_we_o=1.
  - One stall cycle; rd_we_o=0 in DONE.
- LW addr 0x101 with MEM_MISALIGN_EXC_EN:
  - exc_misalign_o=1, dmem_req_o=0, stall_o=0, rd_we_o=0.
  - Without the macro: request to 0x100 with be=4'b1111.
- Reset asserted in WAIT → next cycle state IDLE, dmem_req_o=0, stall_o=0. A late ack is ignored and ldata_q stays 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the req/ack data-memory port and aligns/extends load data.
// Define MEM_MISALIGN_EXC_EN to turn misaligned accesses into bubbles that raise exc_misalign_o.
module mem_access_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int F3_W    = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [XLEN-1:0]    alu_val_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               rd_we_i,
  input  logic [XLEN-1:0]    rs2_val_i,
  input  logic               mem_re_i,
  input  logic               mem_we_i,
  input  logic [F3_W-1:0]    mem_mode_i,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [XLEN-1:0]    dmem_addr_o,
  output logic [3:0]         dmem_be_o,
  output logic [XLEN-1:0]    dmem_wdata_o,
  input  logic [XLEN-1:0]    dmem_rdata_i,
  input  logic               dmem_ack_i,
  output logic               stall_o,
  output logic [XLEN-1:0]    rd_val_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic               rd_we_o,
  output logic               exc_misalign_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [XLEN-1:0] ldata_q;
  logic [XLEN-1:0] load_val;
  logic [1:0]      lane;
  logic            access;
  logic            is_store;
  logic            is_byte;
  logic            is_half;
  logic            misaligned;
  logic            mis_exc;
  logic            req;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  assign lane     = alu_val_i[1:0];
  assign access   = mem_re_i | mem_we_i;
  assign is_store = mem_we_i;

  // Stores only know funct3 000/001 as byte/half; loads also accept the unsigned 1xx forms.
  assign is_byte = (mem_mode_i[1:0] == 2'b00) && !(is_store && mem_mode_i[2]);
  assign is_half = (mem_mode_i[1:0] == 2'b01) && !(is_store && mem_mode_i[2]);

`ifdef MEM_MISALIGN_EXC_EN
  assign misaligned = (is_half && lane[0]) || (!is_byte && !is_half && (lane != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign mis_exc = !rst_i && (state_q == IDLE) && access && misaligned;
  assign req     = !rst_i && (((state_q == IDLE) && access && !misaligned) || (state_q == WAIT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (access && !misaligned) begin
          state_d = dmem_ack_i ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dmem_ack_i) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      if (req && dmem_ack_i && !is_store) begin
        ldata_q <= load_val;
      end
    end
  end

  always_comb begin
    byte_sel = dmem_rdata_i[7:0];
    case (lane)
      2'd0:    byte_sel = dmem_rdata_i[7:0];
      2'd1:    byte_sel = dmem_rdata_i[15:8];
      2'd2:    byte_sel = dmem_rdata_i[23:16];
      default: byte_sel = dmem_rdata_i[31:24];
    endcase
    half_sel = lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    if (is_byte) begin
      load_val = mem_mode_i[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      load_val = mem_mode_i[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end else begin
      load_val = dmem_rdata_i;
    end
  end

  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = rs2_val_i;
    if (is_store && is_byte) begin
      dmem_be_o    = 4'b0001 << lane;
      dmem_wdata_o = {4{rs2_val_i[7:0]}};
    end else if (is_store && is_half) begin
      dmem_be_o    = lane[1] ? 4'b1100 : 4'b0011;
      dmem_wdata_o = {2{rs2_val_i[15:0]}};
    end
  end

  assign dmem_req_o     = req;
  assign dmem_we_o      = mem_we_i;
  assign dmem_addr_o    = {alu_val_i[XLEN-1:2], 2'b00};
  assign stall_o        = req;
  assign exc_misalign_o = mis_exc;
  assign rd_addr_o      = rd_addr_i;

  // Only a plain IDLE pass-through or the DONE cycle of a load may write back.
  always_comb begin
    rd_val_o = alu_val_i;
    rd_we_o  = 1'b0;
    if (!rst_i && !req && !mis_exc) begin
      if (state_q == DONE) begin
        rd_val_o = is_store ? alu_val_i : ldata_q;
        rd_we_o  = rd_we_i & ~mem_we_i;
      end else if (state_q == IDLE && !access) begin
        rd_we_o = rd_we_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a behavioural load/store model.
// Honours MEM_MISALIGN_EXC_EN the same way the design does.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aluVal;
  logic [4:0]  rdAddr;
  logic        rdWe;
  logic [31:0] rs2Val;
  logic        memRe;
  logic        memWe;
  logic [2:0]  memMode;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [3:0]  dmemBe;
  logic [31:0] dmemWdata;
  logic [31:0] dmemRdata;
  logic        dmemAck;
  logic        stall;
  logic [31:0] rdVal;
  logic [4:0]  rdAddrOut;
  logic        rdWeOut;
  logic        excMisalign;

  int checks = 0;
  int failures = 0;

  logic        expValid = 1'b0;
  logic        expReq, expStall, expRdWe, expExc, expWe;
  logic        chkRdVal, chkBus, chkWdata;
  logic [31:0] expRdVal, expAddr, expWdata;
  logic [3:0]  expBe;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk_i(clk), .rst_i(rst), .alu_val_i(aluVal), .rd_addr_i(rdAddr), .rd_we_i(rdWe),
    .rs2_val_i(rs2Val), .mem_re_i(memRe), .mem_we_i(memWe), .mem_mode_i(memMode),
    .dmem_req_o(dmemReq), .dmem_we_o(dmemWe), .dmem_addr_o(dmemAddr), .dmem_be_o(dmemBe),
    .dmem_wdata_o(dmemWdata), .dmem_rdata_i(dmemRdata), .dmem_ack_i(dmemAck),
    .stall_o(stall), .rd_val_o(rdVal), .rd_addr_o(rdAddrOut), .rd_we_o(rdWeOut),
    .exc_misalign_o(excMisalign)
  );

  // Access size in bytes as the instruction set defines it.
  function automatic int sizeOf(input logic isStore, input logic [2:0] mode);
    if (isStore) return (mode == 3'd0) ? 1 : (mode == 3'd1) ? 2 : 4;
    return (mode % 4 == 0) ? 1 : (mode % 4 == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [31:0] addr,
                                            input logic [2:0] mode);
    longint v;
    int a;
    int sz;
    a  = int'(addr % 4);
    sz = sizeOf(1'b0, mode);
    v  = longint'(w);
    if (sz == 1) begin
      v = (v / (longint'(1) << (8 * a))) % 256;
      if (mode < 4 && v >= 128) v = v - 256;
    end else if (sz == 2) begin
      v = (v / ((a >= 2) ? 65536 : 1)) % 65536;
      if (mode < 4 && v >= 32768) v = v - 65536;
    end
    return 32'(v);
  endfunction

  function automatic logic [3:0] modelBe(input logic isStore, input logic [31:0] addr,
                                         input logic [2:0] mode);
    int a;
    int sz;
    a  = int'(addr % 4);
    sz = sizeOf(isStore, mode);
    if (!isStore || sz == 4) return 4'hF;
    if (sz == 1) return 4'(1 << a);
    return (a >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [31:0] rs2, input logic [2:0] mode);
    int sz;
    sz = sizeOf(1'b1, mode);
    if (sz == 1) return {4{rs2[7:0]}};
    if (sz == 2) return {2{rs2[15:0]}};
    return rs2;
  endfunction

  function automatic logic modelMis(input logic isStore, input logic [31:0] addr,
                                    input logic [2:0] mode);
`ifdef MEM_MISALIGN_EXC_EN
    return (addr % sizeOf(isStore, mode)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: model pins first, then every meaningful cycle on the falling edge.
  initial begin
    checkOutput("pin_lb", modelLoad(32'h80FFFFFF, 32'h103, 3'b000), 32'hFFFFFF80);
    checkOutput("pin_lbu", modelLoad(32'h80FFFFFF, 32'h103, 3'b100), 32'h00000080);
    checkOutput("pin_lh", modelLoad(32'h8001F00F, 32'h102, 3'b001), 32'hFFFF8001);
    checkOutput("pin_sh_be", {28'b0, modelBe(1'b1, 32'h202, 3'b001)}, 32'h0000000C);
    checkOutput("pin_sh_wdata", modelWdata(32'hAAAA5555, 3'b001), 32'h55555555);
    forever begin
      @(negedge clk);
      if (expValid) begin
        checkOutput("stall", {31'b0, stall}, {31'b0, expStall});
        checkOutput("req", {31'b0, dmemReq}, {31'b0, expReq});
        checkOutput("rd_we", {31'b0, rdWeOut}, {31'b0, expRdWe});
        checkOutput("exc", {31'b0, excMisalign}, {31'b0, expExc});
        checkOutput("rd_addr", {27'b0, rdAddrOut}, {27'b0, rdAddr});
        if (chkRdVal) checkOutput("rd_val", rdVal, expRdVal);
        if (chkBus) begin
          checkOutput("addr", dmemAddr, expAddr);
          checkOutput("be", {28'b0, dmemBe}, {28'b0, expBe});
          checkOutput("dmem_we", {31'b0, dmemWe}, {31'b0, expWe});
        end
        if (chkWdata) checkOutput("wdata", dmemWdata, expWdata);
      end
    end
  end

  task automatic setIdleExp(input logic rdWeExp, input logic rdValChk, input logic [31:0] val);
    expValid = 1'b1;
    expReq   = 1'b0;
    expStall = 1'b0;
    expExc   = 1'b0;
    expRdWe  = rdWeExp;
    chkRdVal = rdValChk;
    expRdVal = val;
    chkBus   = 1'b0;
    chkWdata = 1'b0;
  endtask

  // One full instruction: drives inputs, plays the memory with the given ack delay, sets expectations.
  task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] rs2, input logic re,
                               input logic we, input logic [2:0] mode, input logic rdwe,
                               input int delay, input logic [31:0] rdata,
                               input logic litEn, input logic [31:0] litVal);
    logic acc;
    acc = re | we;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    aluVal  = alu;
    rs2Val  = rs2;
    memRe   = re;
    memWe   = we;
    memMode = mode;
    rdWe    = rdwe;
    rdAddr  = 5'($urandom);
    if (!acc) begin
      dmemAck   = 1'($urandom);
      dmemRdata = $urandom;
      setIdleExp(rdwe, 1'b1, alu);
      return;
    end
    if (modelMis(we, alu, mode)) begin
      dmemAck   = 1'($urandom);
      dmemRdata = $urandom;
      setIdleExp(1'b0, 1'b0, 32'h0);
      expExc = 1'b1;
      return;
    end
    for (int k = 0; k <= delay; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      dmemAck   = (k == delay);
      dmemRdata = (k == delay) ? rdata : $urandom;
      setIdleExp(1'b0, 1'b0, 32'h0);
      expReq   = 1'b1;
      expStall = 1'b1;
      chkBus   = 1'b1;
      expAddr  = {alu[31:2], 2'b00};
      expBe    = modelBe(we, alu, mode);
      expWe    = we;
      chkWdata = we;
      expWdata = modelWdata(rs2, mode);
    end
    @(posedge clk);
    #1;
    dmemAck   = 1'($urandom);
    dmemRdata = $urandom;
    setIdleExp(rdwe & ~we, 1'b1,
               we ? alu : (litEn ? litVal : modelLoad(rdata, alu, mode)));
  endtask

  initial begin
    rst       = 1'b1;
    aluVal    = 32'h104;
    rs2Val    = 32'h0;
    memRe     = 1'b1;
    memWe     = 1'b0;
    memMode   = 3'b010;
    rdWe      = 1'b1;
    rdAddr    = 5'd3;
    dmemAck   = 1'b1;
    dmemRdata = 32'h0;
    setIdleExp(1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);

    applyStimulus(32'h1234, 32'h0, 1'b0, 1'b0, 3'b010, 1'b1, 0, 32'h0, 1'b0, 32'h0);
    applyStimulus(32'h100, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 2, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    applyStimulus(32'h103, 32'h0, 1'b1, 1'b0, 3'b000, 1'b1, 1, 32'h80FFFFFF, 1'b1, 32'hFFFFFF80);
    applyStimulus(32'h103, 32'h0, 1'b1, 1'b0, 3'b100, 1'b1, 0, 32'h80FFFFFF, 1'b1, 32'h00000080);
    applyStimulus(32'h202, 32'hAAAA5555, 1'b0, 1'b1, 3'b001, 1'b1, 0, 32'h0, 1'b0, 32'h0);
    applyStimulus(32'h101, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 1, 32'h11223344, 1'b1, 32'h11223344);

    // Reset while waiting on ack, then a late ack that must be ignored.
    @(posedge clk);
    #1;
    aluVal  = 32'h300;
    memRe   = 1'b1;
    memWe   = 1'b0;
    memMode = 3'b010;
    rdWe    = 1'b1;
    dmemAck = 1'b0;
    setIdleExp(1'b0, 1'b0, 32'h0);
    expReq   = 1'b1;
    expStall = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    setIdleExp(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    memRe     = 1'b0;
    aluVal    = 32'h55;
    dmemAck   = 1'b1;
    dmemRdata = 32'hCAFEF00D;
    setIdleExp(1'b1, 1'b1, 32'h55);

    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      applyStimulus($urandom, $urandom, kind == 1 || kind == 3, kind >= 2,
                    3'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 3),
                    $urandom, 1'b0, 32'h0);
    end

    @(negedge clk);
    #1;
    expValid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
